// File: rtl/serial_tx.sv
// serial_tx: 8N1 serial transmitter fed by a small byte FIFO.
// Buffered bytes go out back to back, separated by two idle-high cycles.
module serial_tx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        i_Clock,
    input  logic                        i_Rst_n,
    input  logic                        i_Tx_DV,
    input  logic [7:0]                  i_Tx_Byte,
    output logic                        o_Tx_Ready,
    output logic                        o_Tx_Serial,
    output logic                        o_Tx_Active,
    output logic                        o_Tx_Done,
    output logic [$clog2(FIFO_DEPTH):0] o_Fifo_Count
);

    localparam int                PTR_W       = $clog2(FIFO_DEPTH);
    localparam int                CNT_W       = PTR_W + 1;
    localparam logic [CNT_W-1:0]  LP_FULL     = CNT_W'(FIFO_DEPTH);
    localparam logic [15:0]       LP_BIT_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4
    } state_t;

    state_t           r_State;
    logic [15:0]      r_Clk_Cnt;
    logic [2:0]       r_Bit_Idx;
    logic [7:0]       r_Shift;
    logic             r_Serial;
    logic             r_Active;
    logic             r_Done;
    logic [7:0]       r_Mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_Wr_Ptr;
    logic [PTR_W-1:0] r_Rd_Ptr;
    logic [CNT_W-1:0] r_Count;

    state_t           w_Next_State;
    logic [15:0]      w_Next_Clk_Cnt;
    logic [2:0]       w_Next_Bit_Idx;
    logic [7:0]       w_Next_Shift;
    logic             w_Next_Serial;
    logic             w_Next_Active;
    logic             w_Next_Done;
    logic             w_Pop;
    logic             w_Push;
    logic             w_Bit_End;
    logic             w_Fifo_Empty;
    logic             w_Fifo_Full;

    assign w_Fifo_Full  = (r_Count == LP_FULL);
    assign w_Fifo_Empty = (r_Count == '0);
    assign w_Push       = i_Tx_DV && !w_Fifo_Full;
    assign w_Bit_End    = (r_Clk_Cnt == LP_BIT_LAST);

    always_ff @(posedge i_Clock) begin
        if (w_Push) begin
            r_Mem[r_Wr_Ptr] <= i_Tx_Byte;
        end
    end

    // A full FIFO refuses writes even when the FSM pops in the same cycle.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_Wr_Ptr <= '0;
            r_Rd_Ptr <= '0;
            r_Count  <= '0;
        end else begin
            if (w_Push) begin
                r_Wr_Ptr <= r_Wr_Ptr + PTR_W'(1);
            end
            if (w_Pop) begin
                r_Rd_Ptr <= r_Rd_Ptr + PTR_W'(1);
            end
            if (w_Push && !w_Pop) begin
                r_Count <= r_Count + CNT_W'(1);
            end else if (!w_Push && w_Pop) begin
                r_Count <= r_Count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_State   <= IDLE;
            r_Clk_Cnt <= '0;
            r_Bit_Idx <= '0;
            r_Shift   <= '0;
            r_Serial  <= 1'b1;
            r_Active  <= 1'b0;
            r_Done    <= 1'b0;
        end else begin
            r_State   <= w_Next_State;
            r_Clk_Cnt <= w_Next_Clk_Cnt;
            r_Bit_Idx <= w_Next_Bit_Idx;
            r_Shift   <= w_Next_Shift;
            r_Serial  <= w_Next_Serial;
            r_Active  <= w_Next_Active;
            r_Done    <= w_Next_Done;
        end
    end

    always_comb begin
        w_Next_State   = r_State;
        w_Next_Clk_Cnt = r_Clk_Cnt;
        w_Next_Bit_Idx = r_Bit_Idx;
        w_Next_Shift   = r_Shift;
        w_Next_Serial  = r_Serial;
        w_Next_Active  = r_Active;
        w_Next_Done    = 1'b0;
        w_Pop          = 1'b0;

        case (r_State)
            IDLE: begin
                w_Next_Serial  = 1'b1;
                w_Next_Active  = 1'b0;
                w_Next_Clk_Cnt = '0;
                w_Next_Bit_Idx = '0;
                if (!w_Fifo_Empty) begin
                    w_Pop         = 1'b1;
                    w_Next_Shift  = r_Mem[r_Rd_Ptr];
                    w_Next_Serial = 1'b0;
                    w_Next_Active = 1'b1;
                    w_Next_State  = START;
                end
            end
            START: begin
                if (w_Bit_End) begin
                    w_Next_Clk_Cnt = '0;
                    w_Next_Bit_Idx = '0;
                    w_Next_Serial  = r_Shift[0];
                    w_Next_State   = DATA;
                end else begin
                    w_Next_Clk_Cnt = r_Clk_Cnt + 16'd1;
                end
            end
            DATA: begin
                if (w_Bit_End) begin
                    w_Next_Clk_Cnt = '0;
                    if (r_Bit_Idx == 3'd7) begin
                        w_Next_Serial = 1'b1;
                        w_Next_State  = STOP;
                    end else begin
                        w_Next_Bit_Idx = r_Bit_Idx + 3'd1;
                        w_Next_Serial  = r_Shift[r_Bit_Idx + 3'd1];
                    end
                end else begin
                    w_Next_Clk_Cnt = r_Clk_Cnt + 16'd1;
                end
            end
            STOP: begin
                if (w_Bit_End) begin
                    w_Next_Clk_Cnt = '0;
                    w_Next_Active  = 1'b0;
                    w_Next_Done    = 1'b1;
                    w_Next_State   = CLEANUP;
                end else begin
                    w_Next_Clk_Cnt = r_Clk_Cnt + 16'd1;
                end
            end
            CLEANUP: begin
                w_Next_Serial = 1'b1;
                w_Next_State  = IDLE;
            end
            default: begin
                w_Next_State   = IDLE;
                w_Next_Serial  = 1'b1;
                w_Next_Active  = 1'b0;
                w_Next_Clk_Cnt = '0;
                w_Next_Bit_Idx = '0;
            end
        endcase
    end

    assign o_Tx_Serial  = r_Serial;
    assign o_Tx_Active  = r_Active;
    assign o_Tx_Done    = r_Done;
    assign o_Fifo_Count = r_Count;
    assign o_Tx_Ready   = !w_Fifo_Full;

endmodule
